traffic_light_ctrl: RTL and testbench

- Parametrised successor to the team's fixed-timing traffic light FSM; drives one main/side intersection with a pedestrian walk phase.
- Adds an internal phase timer paced by an external tick enable, run-time programmable durations, sensor-extended side green, and a latched walk request with an acknowledge pulse.
- Sits between the input synchronisers (sensor, walk button, program strobe) and the LED drivers.

---
 rtl/traffic_light_ctrl_pkg.sv | 45 ++++
 rtl/traffic_light_ctrl_if.sv | 11 +
 rtl/traffic_light_ctrl_phase_timer.sv | 33 +++
 rtl/traffic_light_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/traffic_light_ctrl_pkg.sv
// Shared types for the traffic light controller: state encoding, LED patterns, program selects.
// ALL_RED_EN adds the ALL_RED state to the encoding.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_MAIN_GREEN  = 3'd0,
        ST_MAIN_YELLOW = 3'd1,
        ST_WALK        = 3'd2,
        ST_SIDE_GREEN  = 3'd3,
        ST_SIDE_YELLOW = 3'd4
`ifdef ALL_RED_EN
        , ST_ALL_RED   = 3'd5
`endif
    } state_t;

    typedef enum logic [1:0] {
        SEL_BASE = 2'd0,
        SEL_EXT  = 2'd1,
        SEL_YEL  = 2'd2,
        SEL_NONE = 2'd3
    } prog_sel_t;

    // Bit order [Rm,Ym,Gm,Rs,Ys,Gs,Walk]
    localparam logic [6:0] LED_MAIN_GREEN  = 7'b0011000;
    localparam logic [6:0] LED_MAIN_YELLOW = 7'b0101000;
    localparam logic [6:0] LED_WALK        = 7'b1001001;
    localparam logic [6:0] LED_SIDE_GREEN  = 7'b1000010;
    localparam logic [6:0] LED_SIDE_YELLOW = 7'b1000100;
    localparam logic [6:0] LED_ALL_RED     = 7'b1001000;

    function automatic logic [6:0] led_pattern(input state_t st);
        case (st)
            ST_MAIN_GREEN:  led_pattern = LED_MAIN_GREEN;
            ST_MAIN_YELLOW: led_pattern = LED_MAIN_YELLOW;
            ST_WALK:        led_pattern = LED_WALK;
            ST_SIDE_GREEN:  led_pattern = LED_SIDE_GREEN;
            ST_SIDE_YELLOW: led_pattern = LED_SIDE_YELLOW;
`ifdef ALL_RED_EN
            ST_ALL_RED:     led_pattern = LED_ALL_RED;
`endif
            default:        led_pattern = LED_MAIN_GREEN;
        endcase
    endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Duration programming bus: one-cycle strobe, field select and new value.
interface traffic_light_ctrl_if #(
    parameter int TW = 4
);
    logic          prog_sync;
    logic [1:0]    prog_sel;
    logic [TW-1:0] prog_value;

    modport master (output prog_sync, prog_sel, prog_value);
    modport slave  (input  prog_sync, prog_sel, prog_value);
endinterface

// File: rtl/traffic_light_ctrl_phase_timer.sv
// Tick-paced down-counter; terminal flags the tick on which the loaded count reaches zero.
module phase_timer #(
    parameter int           W       = 5,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         tick,
    output logic         terminal,
    output logic [W-1:0] count
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] count_q;

    assign terminal = tick && (count_q == '0);
    assign count    = count_q;

    // Load wins over decrement; count holds while tick is low
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= RST_VAL;
        end else if (load) begin
            count_q <= load_value;
        end else if (tick && (count_q != '0)) begin
            count_q <= count_q - ONE;
        end else begin
            count_q <= count_q;
        end
    end
endmodule

// File: rtl/traffic_light_ctrl.sv
// Main/side intersection controller with walk phase, programmable durations and sensor extension.
// Define ALL_RED_EN to insert a one-tick ALL_RED phase after each yellow.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int TW     = 4,
    parameter int T_BASE = 6,
    parameter int T_EXT  = 3,
    parameter int T_YEL  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 sensor_sync,
    input  logic                 walk_req,
    traffic_light_ctrl_if.slave  prog,
    output logic [6:0]           leds,
    output logic                 walk_req_clr,
    output logic [2:0]           state_o,
    output logic [TW:0]          time_left
);
    localparam logic [TW-1:0] BASE_RST = TW'(T_BASE);
    localparam logic [TW-1:0] EXT_RST  = TW'(T_EXT);
    localparam logic [TW-1:0] YEL_RST  = TW'(T_YEL);
    localparam logic [TW:0]   CNT_RST  = (TW+1)'(2 * T_BASE - 1);
    localparam logic [TW:0]   ONE      = (TW+1)'(1);

    state_t        state_q, state_d, nxt_fsm_s;
    logic [TW-1:0] base_q, base_d, ext_q, ext_d, yel_q, yel_d;
    logic          walk_pend_q, walk_clr_q, walk_enter_s, walk_fsm_s;
    logic [6:0]    leds_q;
    logic          prog_ok_s, term_s, load_s, ld_fsm_s;
    logic [TW:0]   load_val_s, val_fsm_s, count_s;
    logic [TW:0]   mg_m1_s, restart_m1_s, sg_m1_s, yel_m1_s, ext_m1_s;
`ifdef ALL_RED_EN
    logic          red_to_main_q, red_to_main_d;
`endif

    phase_timer #(
        .W       (TW + 1),
        .RST_VAL (CNT_RST)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (load_s),
        .load_value (load_val_s),
        .tick       (tick),
        .terminal   (term_s),
        .count      (count_s)
    );

    // Duration register writes and the phase lengths (minus one) they imply
    always_comb begin
        prog_ok_s = prog.prog_sync && (prog.prog_sel != SEL_NONE) && (prog.prog_value != '0);
        base_d = base_q;
        ext_d  = ext_q;
        yel_d  = yel_q;
        if (prog_ok_s) begin
            case (prog_sel_t'(prog.prog_sel))
                SEL_BASE: base_d = prog.prog_value;
                SEL_EXT:  ext_d  = prog.prog_value;
                SEL_YEL:  yel_d  = prog.prog_value;
                default:  base_d = base_q;
            endcase
        end else begin
            base_d = base_q;
        end
        mg_m1_s      = {base_q, 1'b0} - ONE;
        restart_m1_s = {base_d, 1'b0} - ONE;
        yel_m1_s     = {1'b0, yel_q} - ONE;
        ext_m1_s     = {1'b0, ext_q} - ONE;
        if (sensor_sync) begin
            sg_m1_s = {1'b0, base_q} + {1'b0, ext_q} - ONE;
        end else begin
            sg_m1_s = {1'b0, base_q} - ONE;
        end
    end

    // Phase sequencing; a valid program write overrides any transition
    always_comb begin
        nxt_fsm_s  = state_q;
        ld_fsm_s   = 1'b0;
        val_fsm_s  = mg_m1_s;
        walk_fsm_s = 1'b0;
`ifdef ALL_RED_EN
        red_to_main_d = red_to_main_q;
`endif
        case (state_q)
            ST_MAIN_GREEN: begin
                if (term_s) begin
                    nxt_fsm_s = ST_MAIN_YELLOW;
                    ld_fsm_s  = 1'b1;
                    val_fsm_s = yel_m1_s;
                end else begin
                    nxt_fsm_s = state_q;
                end
            end
            ST_MAIN_YELLOW: begin
                if (term_s) begin
                    ld_fsm_s = 1'b1;
`ifdef ALL_RED_EN
                    nxt_fsm_s     = ST_ALL_RED;
                    val_fsm_s     = '0;
                    red_to_main_d = 1'b0;
`else
                    if (walk_pend_q) begin
                        nxt_fsm_s  = ST_WALK;
                        val_fsm_s  = ext_m1_s;
                        walk_fsm_s = 1'b1;
                    end else begin
                        nxt_fsm_s = ST_SIDE_GREEN;
                        val_fsm_s = sg_m1_s;
                    end
`endif
                end else begin
                    nxt_fsm_s = state_q;
                end
            end
            ST_WALK: begin
                if (term_s) begin
                    nxt_fsm_s = ST_SIDE_GREEN;
                    ld_fsm_s  = 1'b1;
                    val_fsm_s = sg_m1_s;
                end else begin
                    nxt_fsm_s = state_q;
                end
            end
            ST_SIDE_GREEN: begin
                if (term_s) begin
                    nxt_fsm_s = ST_SIDE_YELLOW;
                    ld_fsm_s  = 1'b1;
                    val_fsm_s = yel_m1_s;
                end else begin
                    nxt_fsm_s = state_q;
                end
            end
            ST_SIDE_YELLOW: begin
                if (term_s) begin
                    ld_fsm_s = 1'b1;
`ifdef ALL_RED_EN
                    nxt_fsm_s     = ST_ALL_RED;
                    val_fsm_s     = '0;
                    red_to_main_d = 1'b1;
`else
                    nxt_fsm_s = ST_MAIN_GREEN;
                    val_fsm_s = mg_m1_s;
`endif
                end else begin
                    nxt_fsm_s = state_q;
                end
            end
`ifdef ALL_RED_EN
            ST_ALL_RED: begin
                if (term_s) begin
                    ld_fsm_s = 1'b1;
                    if (red_to_main_q) begin
                        nxt_fsm_s = ST_MAIN_GREEN;
                        val_fsm_s = mg_m1_s;
                    end else if (walk_pend_q) begin
                        nxt_fsm_s  = ST_WALK;
                        val_fsm_s  = ext_m1_s;
                        walk_fsm_s = 1'b1;
                    end else begin
                        nxt_fsm_s = ST_SIDE_GREEN;
                        val_fsm_s = sg_m1_s;
                    end
                end else begin
                    nxt_fsm_s = state_q;
                end
            end
`endif
            default: begin
                nxt_fsm_s = ST_MAIN_GREEN;
                ld_fsm_s  = 1'b1;
                val_fsm_s = mg_m1_s;
            end
        endcase

        if (prog_ok_s) begin
            state_d      = ST_MAIN_GREEN;
            load_s       = 1'b1;
            load_val_s   = restart_m1_s;
            walk_enter_s = 1'b0;
        end else begin
            state_d      = nxt_fsm_s;
            load_s       = ld_fsm_s;
            load_val_s   = val_fsm_s;
            walk_enter_s = walk_fsm_s;
        end
    end

    // State, durations, walk latch and registered LED decode
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_MAIN_GREEN;
            base_q      <= BASE_RST;
            ext_q       <= EXT_RST;
            yel_q       <= YEL_RST;
            walk_pend_q <= 1'b0;
            walk_clr_q  <= 1'b0;
            leds_q      <= LED_MAIN_GREEN;
`ifdef ALL_RED_EN
            red_to_main_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            ext_q       <= ext_d;
            yel_q       <= yel_d;
            // A request on the serving edge re-arms the latch
            walk_pend_q <= walk_req | (walk_pend_q & ~walk_enter_s);
            walk_clr_q  <= walk_enter_s;
            leds_q      <= led_pattern(state_d);
`ifdef ALL_RED_EN
            red_to_main_q <= red_to_main_d;
`endif
        end
    end

    assign leds         = leds_q;
    assign walk_req_clr = walk_clr_q;
    assign state_o      = state_q;
    assign time_left    = count_s;
endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: phase tables plus hand-written program/freeze/reset sequences.
module tb_traffic_light_ctrl;
    localparam logic [6:0] L_MG = 7'b0011000;
    localparam logic [6:0] L_MY = 7'b0101000;
    localparam logic [6:0] L_WK = 7'b1001001;
    localparam logic [6:0] L_SG = 7'b1000010;
    localparam logic [6:0] L_SY = 7'b1000100;
    localparam logic [6:0] L_AR = 7'b1001000;

    logic       clk = 1'b0;
    logic       reset, tick, sensor_sync, walk_req;
    logic [6:0] leds;
    logic       walk_req_clr;
    logic [2:0] state_o;
    logic [4:0] time_left;

    traffic_light_ctrl_if #(.TW(4)) prog_if ();

    traffic_light_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .sensor_sync  (sensor_sync),
        .walk_req     (walk_req),
        .prog         (prog_if),
        .leds         (leds),
        .walk_req_clr (walk_req_clr),
        .state_o      (state_o),
        .time_left    (time_left)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] leds;
        logic [4:0] tl;
        logic       clr;
    } exp_t;

    typedef struct {
        logic [6:0] leds;
        int         n;
        int         tl0;
        logic       sensor;
        logic       walk;
        logic       clr;
    } phase_t;

    exp_t   sb_q[$];
    phase_t ph_q[$];
    int     n_checks = 0;
    int     n_pass   = 0;

    // Compare current outputs, then drive this cycle's inputs and advance one clock
    task automatic cyc(input logic rst, input logic tk, input logic wk, input logic sn,
                       input logic ps, input logic [1:0] sel, input logic [3:0] val,
                       input logic [6:0] el, input logic [4:0] et, input logic ec,
                       input string nm);
        exp_t want;
        exp_t got;
        sb_q.push_back({el, et, ec});
        want = sb_q.pop_front();
        got  = {leds, time_left, walk_req_clr};
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got leds=%b time_left=%0d clr=%b, expected leds=%b time_left=%0d clr=%b",
                     nm, $time, got.leds, got.tl, got.clr, want.leds, want.tl, want.clr);
        end
        reset               = rst;
        tick                = tk;
        walk_req            = wk;
        sensor_sync         = sn;
        prog_if.prog_sync   = ps;
        prog_if.prog_sel    = sel;
        prog_if.prog_value  = val;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [6:0] l, input int n, input int tl0,
                       input logic s, input logic w, input logic c);
        phase_t p;
        p.leds = l; p.n = n; p.tl0 = tl0; p.sensor = s; p.walk = w; p.clr = c;
        ph_q.push_back(p);
    endtask

    task automatic add_yel(input logic [6:0] l, input int n, input logic s, input logic w);
        add(l, n, n - 1, s, w, 1'b0);
`ifdef ALL_RED_EN
        add(L_AR, 1, 0, s, w, 1'b0);
`endif
    endtask

    task automatic run_phases();
        while (ph_q.size() > 0) begin
            phase_t p;
            p = ph_q.pop_front();
            for (int k = 0; k < p.n; k++) begin
                cyc(1'b0, 1'b1, p.walk, p.sensor, 1'b0, 2'd0, 4'd0,
                    p.leds, 5'(p.tl0 - k), p.clr && (k == 0), "phase");
            end
        end
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; walk_req = 1'b0; sensor_sync = 1'b0;
        prog_if.prog_sync = 1'b0; prog_if.prog_sel = 2'd0; prog_if.prog_value = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Default cycle, walk request served, set-wins on serve edge, sensor extension
        add(L_MG, 12, 11, 1'b0, 1'b0, 1'b0);
        add_yel(L_MY, 2, 1'b0, 1'b0);
        add(L_SG, 6, 5, 1'b0, 1'b0, 1'b0);
        add_yel(L_SY, 2, 1'b0, 1'b0);
        add(L_MG, 1, 11, 1'b0, 1'b1, 1'b0);
        add(L_MG, 11, 10, 1'b0, 1'b0, 1'b0);
        add_yel(L_MY, 2, 1'b1, 1'b1);
        add(L_WK, 3, 2, 1'b1, 1'b0, 1'b1);
        add(L_SG, 9, 8, 1'b0, 1'b0, 1'b0);
        add_yel(L_SY, 2, 1'b0, 1'b0);
        add(L_MG, 12, 11, 1'b0, 1'b0, 1'b0);
        add_yel(L_MY, 2, 1'b0, 1'b0);
        add(L_WK, 3, 2, 1'b0, 1'b0, 1'b1);
        add(L_SG, 6, 5, 1'b0, 1'b0, 1'b0);
        add_yel(L_SY, 2, 1'b0, 1'b0);
        add(L_MG, 12, 11, 1'b0, 1'b0, 1'b0);
        add_yel(L_MY, 2, 1'b0, 1'b0);
        run_phases();

        // Ignored writes mid side green, then yellow=4 restarts at main green
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, L_SG, 5'd5, 1'b0, "sg_pre");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'd0, L_SG, 5'd4, 1'b0, "sg_zero_val");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 4'd5, L_SG, 5'd3, 1'b0, "sg_sel3");
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, 4'd4, L_SG, 5'd2, 1'b0, "sg_prog_yel");
        add(L_MG, 12, 11, 1'b0, 1'b0, 1'b0);
        add_yel(L_MY, 4, 1'b0, 1'b0);
        add(L_SG, 6, 5, 1'b0, 1'b0, 1'b0);
        add_yel(L_SY, 4, 1'b0, 1'b0);
        add(L_MG, 11, 11, 1'b0, 1'b0, 1'b0);
        run_phases();

        // Write base=4 on the terminal tick: restart beats the transition
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 4'd4, L_MG, 5'd0, 1'b0, "mg_term_prog");
        add(L_MG, 8, 7, 1'b0, 1'b0, 1'b0);
        add_yel(L_MY, 4, 1'b0, 1'b0);
        add(L_SG, 4, 3, 1'b0, 1'b0, 1'b0);
        add_yel(L_SY, 4, 1'b0, 1'b0);
        run_phases();

        // Timer frozen while tick is low
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, L_MG, 5'd7, 1'b0, "mg_new_base");
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, L_MG, 5'd6, 1'b0, "freeze");
        end

        // Reset mid-walk with a fresh request pending
        add(L_MG, 7, 6, 1'b0, 1'b1, 1'b0);
        add_yel(L_MY, 4, 1'b0, 1'b0);
        run_phases();
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, L_WK, 5'd2, 1'b1, "walk_entry");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0, L_WK, 5'd1, 1'b0, "walk_rearm");
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, L_WK, 5'd0, 1'b0, "walk_reset");
        add(L_MG, 12, 11, 1'b0, 1'b0, 1'b0);
        add_yel(L_MY, 2, 1'b0, 1'b0);
        add(L_SG, 6, 5, 1'b0, 1'b0, 1'b0);
        add_yel(L_SY, 2, 1'b0, 1'b0);
        run_phases();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, L_MG, 5'd11, 1'b0, "final_mg");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
